// File: rtl/lut_pkg.sv
// Shared constants and types for the LUT equivalence checker.
// Holds the control FSM encoding, the legal N_IN range and the evaluation payload.
package lut_pkg;

    localparam int unsigned N_IN_MIN = 2;
    localparam int unsigned N_IN_MAX = 6;

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic ya;
        logic yb;
    } eval_res_t;

endpackage

// File: rtl/lut_table.sv
// One truth table: whole-table write port plus two independent indexed bit reads
// (one for handshake evaluation, one for the equivalence sweep).
module lut_table
    import lut_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    localparam int unsigned DEPTH = 2**N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [DEPTH-1:0] wr_data_i,
    input  logic [N_IN-1:0]  eval_idx_i,
    output logic             eval_bit_c_o,
    input  logic [N_IN-1:0]  sweep_idx_i,
    output logic             sweep_bit_c_o
);

    logic [DEPTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q <= wr_data_i;
        end
    end

    // Reads see the pre-write contents, so a same-cycle load does not leak into an evaluation.
    assign eval_bit_c_o  = mem_q[eval_idx_i];
    assign sweep_bit_c_o = mem_q[sweep_idx_i];

endmodule

// File: rtl/lut_equiv_checker.sv
// Two loadable truth tables with a ready/valid evaluator and a one-index-per-cycle
// equivalence sweep reporting mismatch count, first mismatch and minterm counts.
module lut_equiv_checker
    import lut_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    localparam int unsigned DEPTH = 2**N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tbl_valid,
    output logic             tbl_ready,
    input  logic             tbl_sel,
    input  logic [DEPTH-1:0] tbl_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ya,
    output logic             out_yb,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             eq,
    output logic [N_IN:0]    mism_cnt,
    output logic [N_IN-1:0]  first_mism,
    output logic [N_IN:0]    ones_a,
    output logic [N_IN:0]    ones_b
);

    localparam int unsigned CNT_W = N_IN + 1;

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("lut_equiv_checker: N_IN outside legal range");
    end

    logic [ST_W-1:0]  state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] ones_a_q, ones_a_d;
    logic [CNT_W-1:0] ones_b_q, ones_b_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic             found_q, found_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             eq_q, eq_d;
    logic             out_valid_q, out_valid_d;
    eval_res_t        res_q, res_d;

    logic tbl_ready_c;
    logic in_ready_c;
    logic tbl_fire_c;
    logic in_fire_c;
    logic a_eval_c, b_eval_c;
    logic a_sweep_c, b_sweep_c;

    assign tbl_ready_c = (state_q != ST_SWEEP);
    assign in_ready_c  = (~out_valid_q | out_ready) & (state_q != ST_SWEEP);
    assign tbl_fire_c  = tbl_valid & tbl_ready_c;
    assign in_fire_c   = in_valid & in_ready_c;

    lut_table #(.N_IN(N_IN)) u_tbl_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (tbl_fire_c & ~tbl_sel),
        .wr_data_i     (tbl_data),
        .eval_idx_i    (in_vec),
        .eval_bit_c_o  (a_eval_c),
        .sweep_idx_i   (idx_q),
        .sweep_bit_c_o (a_sweep_c)
    );

    lut_table #(.N_IN(N_IN)) u_tbl_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (tbl_fire_c & tbl_sel),
        .wr_data_i     (tbl_data),
        .eval_idx_i    (in_vec),
        .eval_bit_c_o  (b_eval_c),
        .sweep_idx_i   (idx_q),
        .sweep_bit_c_o (b_sweep_c)
    );

    // Control FSM, sweep accumulation and evaluation handshake next-state logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ones_a_d    = ones_a_q;
        ones_b_d    = ones_b_q;
        mism_d      = mism_q;
        first_d     = first_q;
        found_d     = found_q;
        done_d      = 1'b0;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sweep_start) begin
                    state_d  = ST_SWEEP;
                    idx_d    = '0;
                    ones_a_d = '0;
                    ones_b_d = '0;
                    mism_d   = '0;
                    first_d  = '0;
                    found_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                ones_a_d = ones_a_q + CNT_W'(a_sweep_c);
                ones_b_d = ones_b_q + CNT_W'(b_sweep_c);
                if (a_sweep_c != b_sweep_c) begin
                    mism_d = mism_q + CNT_W'(1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = idx_q;
                    end
                end
                // Last index holds the counter rather than wrapping back to 0.
                if (idx_q == N_IN'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SWEEP);
        eq_d   = (mism_d == '0);

        if (in_fire_c) begin
            out_valid_d = 1'b1;
            res_d.ya    = a_eval_c;
            res_d.yb    = b_eval_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ones_a_q    <= '0;
            ones_b_q    <= '0;
            mism_q      <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            eq_q        <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ones_a_q    <= ones_a_d;
            ones_b_q    <= ones_b_d;
            mism_q      <= mism_d;
            first_q     <= first_d;
            found_q     <= found_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign tbl_ready  = tbl_ready_c;
    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign out_ya     = res_q.ya;
    assign out_yb     = res_q.yb;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign eq         = eq_q;
    assign mism_cnt   = mism_q;
    assign first_mism = first_q;
    assign ones_a     = ones_a_q;
    assign ones_b     = ones_b_q;

endmodule

// File: tb/tb_lut_equiv_checker.sv
// Self-checking bench for lut_equiv_checker (N_IN=3) against a bit-vector reference model.
`timescale 1ns/1ps
module tb_lut_equiv_checker;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic             tbl_valid;
    logic             tbl_ready;
    logic             tbl_sel;
    logic [DEPTH-1:0] tbl_data;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic             out_ya;
    logic             out_yb;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic             eq;
    logic [N_IN:0]    mism_cnt;
    logic [N_IN-1:0]  first_mism;
    logic [N_IN:0]    ones_a;
    logic [N_IN:0]    ones_b;

    int errors = 0;
    int checks = 0;
    logic [DEPTH-1:0] ref_a;
    logic [DEPTH-1:0] ref_b;

    lut_equiv_checker #(.N_IN(N_IN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tbl_valid   (tbl_valid),
        .tbl_ready   (tbl_ready),
        .tbl_sel     (tbl_sel),
        .tbl_data    (tbl_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ya      (out_ya),
        .out_yb      (out_yb),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .eq          (eq),
        .mism_cnt    (mism_cnt),
        .first_mism  (first_mism),
        .ones_a      (ones_a),
        .ones_b      (ones_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tbl(input logic sel, input logic [DEPTH-1:0] data);
        tbl_sel   = sel;
        tbl_data  = data;
        tbl_valid = 1'b1;
        #1;
        check_eq("tbl_ready_load", 32'(tbl_ready), 32'd1);
        step();
        tbl_valid = 1'b0;
        if (sel) ref_b = data;
        else     ref_a = data;
    endtask

    // Sweep with expectations derived from whole-table arithmetic; optionally hammer
    // loads, evaluations and restarts while the sweep runs.
    task automatic run_sweep(input logic disturb);
        int busy_n;
        int lat;
        logic seen;
        logic [DEPTH-1:0] diff;
        int exp_first;
        diff = ref_a ^ ref_b;
        exp_first = 0;
        for (int i = DEPTH - 1; i >= 0; i--) if (diff[i]) exp_first = i;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        busy_n = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (sweep_done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (sweep_busy) busy_n++;
                if (disturb) begin
                    tbl_sel     = c[0];
                    tbl_data    = ~(c[0] ? ref_b : ref_a);
                    tbl_valid   = 1'b1;
                    in_vec      = 3'($urandom_range(0, 7));
                    in_valid    = 1'b1;
                    sweep_start = 1'b1;
                    #1;
                    check_eq("tbl_ready_sweep", 32'(tbl_ready), 32'd0);
                    check_eq("in_ready_sweep", 32'(in_ready), 32'd0);
                end
                step();
            end
        end
        tbl_valid   = 1'b0;
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        check_eq("sweep_done_seen", 32'(seen), 32'd1);
        check_eq("sweep_latency", 32'(lat), 32'(DEPTH + 1));
        check_eq("sweep_busy_cycles", 32'(busy_n), 32'(DEPTH));
        check_eq("busy_after_done", 32'(sweep_busy), 32'd0);
        check_eq("eq", 32'(eq), 32'(diff == '0));
        check_eq("mism_cnt", 32'(mism_cnt), 32'($countones(diff)));
        check_eq("first_mism", 32'(first_mism), 32'(exp_first));
        check_eq("ones_a", 32'(ones_a), 32'($countones(ref_a)));
        check_eq("ones_b", 32'(ones_b), 32'($countones(ref_b)));
        step();
        check_eq("sweep_done_pulse", 32'(sweep_done), 32'd0);
        check_eq("results_hold", 32'(mism_cnt), 32'($countones(diff)));
    endtask

    task automatic eval_vec(input logic [N_IN-1:0] v, input int stall);
        logic ea;
        logic eb;
        ea = ref_a[v];
        eb = ref_b[v];
        out_ready = (stall == 0);
        in_vec    = v;
        in_valid  = 1'b1;
        #1;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_out_ya", 32'(out_ya), 32'(ea));
            check_eq("stall_out_yb", 32'(out_yb), 32'(eb));
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_eq("out_valid", 32'(out_valid), 32'd1);
        check_eq("out_ya", 32'(out_ya), 32'(ea));
        check_eq("out_yb", 32'(out_yb), 32'(eb));
        check_eq("in_ready_drain", 32'(in_ready), 32'd1);
        step();
        check_eq("out_valid_clear", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int dn;
        logic [N_IN-1:0] v;
        logic [DEPTH-1:0] ra;
        logic [DEPTH-1:0] rb;
        rst_n = 1'b0; tbl_valid = 1'b0; tbl_sel = 1'b0; tbl_data = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; sweep_start = 1'b0;
        ref_a = '0; ref_b = '0;
        repeat (2) step();
        check_eq("rst_eq", 32'(eq), 32'd1);
        check_eq("rst_busy", 32'(sweep_busy), 32'd0);
        check_eq("rst_done", 32'(sweep_done), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mism", 32'(mism_cnt), 32'd0);
        check_eq("rst_ones_a", 32'(ones_a), 32'd0);
        check_eq("rst_tbl_ready", 32'(tbl_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Identical tables, then two disagreeing indices.
        load_tbl(1'b0, 8'hB0);
        load_tbl(1'b1, 8'hB0);
        run_sweep(1'b0);
        load_tbl(1'b1, 8'h70);
        run_sweep(1'b0);
        eval_vec(3'b110, 3);

        // Sweep with loads, evaluations and restarts attempted mid-sweep.
        run_sweep(1'b1);
        for (int i = 0; i < DEPTH; i++) eval_vec(3'(i), 0);

        // Same-edge load and evaluation sees the old table.
        load_tbl(1'b0, 8'h00);
        v = 3'($urandom_range(0, 7));
        tbl_sel = 1'b0; tbl_data = 8'hFF; tbl_valid = 1'b1;
        in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_eq("same_edge_in_ready", 32'(in_ready), 32'd1);
        step();
        tbl_valid = 1'b0; in_valid = 1'b0;
        check_eq("same_edge_out_ya", 32'(out_ya), 32'(ref_a[v]));
        ref_a = 8'hFF;
        step();
        eval_vec(v, 0);

        // Full disagreement: mism_cnt reaches DEPTH.
        load_tbl(1'b0, 8'h00);
        load_tbl(1'b1, 8'hFF);
        run_sweep(1'b0);

        // Reset during the sweep aborts it.
        load_tbl(1'b0, 8'hB0);
        load_tbl(1'b1, 8'h70);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        ref_a = '0; ref_b = '0;
        check_eq("arst_busy", 32'(sweep_busy), 32'd0);
        check_eq("arst_done", 32'(sweep_done), 32'd0);
        check_eq("arst_eq", 32'(eq), 32'd1);
        check_eq("arst_mism", 32'(mism_cnt), 32'd0);
        check_eq("arst_first", 32'(first_mism), 32'd0);
        check_eq("arst_ones_a", 32'(ones_a), 32'd0);
        check_eq("arst_ones_b", 32'(ones_b), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_ya", 32'(out_ya), 32'd0);
        check_eq("arst_tbl_ready", 32'(tbl_ready), 32'd1);
        step();
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (sweep_done || sweep_busy) dn++;
            step();
        end
        check_eq("no_done_after_abort", 32'(dn), 32'd0);
        for (int i = 0; i < DEPTH; i++) eval_vec(3'(i), 0);
        load_tbl(1'b0, 8'hB0);
        load_tbl(1'b1, 8'h70);
        run_sweep(1'b0);

        // Randomized tables, sweeps and stalled evaluations.
        for (int it = 0; it < 16; it++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            load_tbl(1'b0, ra);
            load_tbl(1'b1, rb);
            run_sweep(($urandom_range(0, 3) == 0));
            for (int e = 0; e < 3; e++) eval_vec(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_equiv_checker.md
LUT_EQUIV_CHECKER -- requirements
Module: lut_equiv_checker

Interface
REQ-001 Parameter N_IN, default 3, meaning number of function inputs; legal range 2..6.
REQ-002 Parameter DEPTH, default 2**N_IN, derived and not overridden, meaning number of truth-table entries.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tbl_valid  input  1  table-load request.
REQ-006 tbl_ready  output  1  table-load accept.
REQ-007 tbl_sel  input  1  target table: 0=A, 1=B.
REQ-008 tbl_data  input  DEPTH  truth table, bit i = output for input vector i.
REQ-009 in_valid / in_ready  input / output  1  evaluation-request handshake.
REQ-010 in_vec  input  N_IN  input vector; MSB = first variable.
REQ-011 out_valid / out_ready  output / input  1  evaluation-result handshake.
REQ-012 out_ya / out_yb  output  1  table A / table B value at the accepted in_vec.
REQ-013 sweep_start  input  1  single-cycle pulse requesting an equivalence sweep.
REQ-014 sweep_busy  output  1  sweep in progress.
REQ-015 sweep_done  output  1  single-cycle pulse when results become valid.
REQ-016 eq  output  1  1 when tables A and B agree at every index.
REQ-017 mism_cnt  output  N_IN+1  count of disagreeing indices.
REQ-018 first_mism  output  N_IN  lowest disagreeing index; 0 when eq=1.
REQ-019 ones_a / ones_b  output  N_IN+1  minterm count of table A / table B.

Function
REQ-020 Control FSM shall have states IDLE, SWEEP, DONE; reset enters IDLE.
REQ-021 tbl_ready shall be 1 in IDLE and DONE and 0 in SWEEP; tbl_valid&tbl_ready writes tbl_data into the table selected by tbl_sel on that edge.
REQ-022 in_ready shall equal (~out_valid | out_ready) & (state != SWEEP).
REQ-023 in_valid&in_ready shall register out_ya/out_yb and set out_valid the next cycle, giving 1-cycle latency.
REQ-024 out_valid shall stay high, with out_ya/out_yb stable, until out_ready; it then clears unless a new transfer happens on the same edge.
REQ-025 A table load and an evaluation in the same cycle shall evaluate using the pre-load table contents.
REQ-026 sweep_start in IDLE or DONE at edge t shall enter SWEEP, clear all counters, and reset the index to 0.
REQ-027 SWEEP shall process index k at edge t+1+k for k = 0..DEPTH-1, one index per cycle.
REQ-028 Per processed index:
  - add A[k] to ones_a and B[k] to ones_b;
  - on A[k]!=B[k], increment mism_cnt;
  - on the first such disagreement, latch k into first_mism.
REQ-029 After index DEPTH-1 the FSM shall enter DONE; sweep_done shall pulse for exactly one cycle.
REQ-030 eq shall equal (mism_cnt==0) and shall be meaningful only from sweep_done onward.
REQ-031 Results shall hold until the next accepted sweep_start.
REQ-032 sweep_busy shall be 1 exactly while in SWEEP.
REQ-033 sweep_start during SWEEP shall be ignored.
REQ-034 The index counter shall not wrap past DEPTH-1; mism_cnt width N_IN+1 shall hold DEPTH without overflow.
REQ-035 No table load is possible during SWEEP, so sweep results always reflect tables frozen at sweep start.

Reset
REQ-036 rst_n low shall asynchronously force:
  - IDLE;
  - both tables, all counters, first_mism, out_ya, out_yb to 0;
  - out_valid, sweep_busy, sweep_done to 0;
  - eq to 1.
REQ-037 Reset mid-sweep shall abort the sweep with no sweep_done pulse; operation resumes from IDLE on the first edge after release.

Structure
REQ-038 The FSM state encoding and the N_IN legal-range constants shall live in shared package lut_pkg.
REQ-039 Table storage plus indexed read shall be one sub-module, lut_table; it is instantiated twice, once for A and once for B.

Verification (N_IN=3)
REQ-040 Load A=0xB0 and B=0xB0, then pulse sweep_start -> sweep_busy high for 8 cycles, sweep_done at t+9, eq=1, mism_cnt=0, ones_a=ones_b=3.
REQ-041 Load A=0xB0 and B=0x70, then sweep -> eq=0, mism_cnt=2, first_mism=6, ones_a=3, ones_b=3.
REQ-042 Load A=0xB0, B=0x70; in_vec=3'b110 with out_ready held low for 3 cycles -> out_ya=0, out_yb=1, both stable, in_ready=0 until out_ready.
REQ-043 Pulse sweep_start, then attempt tbl_valid and in_valid during SWEEP -> tbl_ready=0, in_ready=0, tables unchanged, sweep results as in REQ-041.
REQ-044 Assert rst_n low at sweep cycle 4 -> all outputs at REQ-036 values, no sweep_done pulse, next sweep after reload completes normally.
REQ-045 Drive tbl_valid (A=0xFF) and in_valid on the same edge with old A=0x00 -> out_ya=0; a following evaluation returns out_ya=1.
